// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: three per-source in-order queues drained
// round-robin into a single registered write port, plus RAW hazard detection
// for the two decode-stage read addresses.
module regfile_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid_3,
  output logic [2:0]  req_ready_3,
  input  logic [4:0]  req_address_0_5,
  input  logic [4:0]  req_address_1_5,
  input  logic [4:0]  req_address_2_5,
  input  logic [31:0] req_data_0_32,
  input  logic [31:0] req_data_1_32,
  input  logic [31:0] req_data_2_32,
  output logic        w_en,
  output logic [4:0]  w_address_d_5,
  output logic [31:0] w_data_dval_32,
  input  logic [4:0]  w_address_s1_5,
  input  logic [4:0]  w_address_s2_5,
  output logic        hazard_s1,
  output logic        hazard_s2,
  output logic        idle
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;

  logic [4:0]  req_addr  [3];
  logic [31:0] req_data  [3];
  logic [4:0]  head_addr [3];
  logic [31:0] head_data [3];

  logic [2:0]  nonempty;
  logic [2:0]  grant_oh;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [1:0]  last_grant;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  logic [3*FIFO_DEPTH-1:0] match_s1;
  logic [3*FIFO_DEPTH-1:0] match_s2;

  assign req_addr[0] = req_address_0_5;
  assign req_addr[1] = req_address_1_5;
  assign req_addr[2] = req_address_2_5;
  assign req_data[0] = req_data_0_32;
  assign req_data[1] = req_data_1_32;
  assign req_data[2] = req_data_2_32;

  for (genvar g = 0; g < 3; g++) begin : g_queue
    // Ring buffer with a per-slot valid flag: full when every slot is valid,
    // empty when none is, so no separate occupancy counter is needed.
    logic [FIFO_DEPTH-1:0] valid;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [4:0]            addr_mem [FIFO_DEPTH];
    logic [31:0]           data_mem [FIFO_DEPTH];
    logic                  push;
    logic                  pop;

    assign req_ready_3[g] = ~&valid;
    assign nonempty[g]    = |valid;
    assign push           = req_valid_3[g] & req_ready_3[g];
    assign pop            = grant_oh[g];
    assign head_addr[g]   = addr_mem[rd_ptr];
    assign head_data[g]   = data_mem[rd_ptr];

    // Occupancy and pointer state; push and pop never target the same slot.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) begin
          valid[rd_ptr] <= 1'b0;
          rd_ptr        <= rd_ptr + 1'b1;
        end
        if (push) begin
          valid[wr_ptr] <= 1'b1;
          wr_ptr        <= wr_ptr + 1'b1;
        end
      end
    end

    // Entry storage; contents are only meaningful where valid is set.
    always_ff @(posedge clock) begin
      if (push) begin
        addr_mem[wr_ptr] <= req_addr[g];
        data_mem[wr_ptr] <= req_data[g];
      end
    end

    for (genvar j = 0; j < FIFO_DEPTH; j++) begin : g_match
      assign match_s1[g*FIFO_DEPTH + j] = valid[j] && (addr_mem[j] == w_address_s1_5);
      assign match_s2[g*FIFO_DEPTH + j] = valid[j] && (addr_mem[j] == w_address_s2_5);
    end
  end

  // Round-robin pick: first non-empty queue after the last granted one.
  always_comb begin
    grant_oh = '0;
    case (last_grant)
      2'd0: begin
        if      (nonempty[1]) grant_oh = 3'b010;
        else if (nonempty[2]) grant_oh = 3'b100;
        else if (nonempty[0]) grant_oh = 3'b001;
      end
      2'd1: begin
        if      (nonempty[2]) grant_oh = 3'b100;
        else if (nonempty[0]) grant_oh = 3'b001;
        else if (nonempty[1]) grant_oh = 3'b010;
      end
      default: begin
        if      (nonempty[0]) grant_oh = 3'b001;
        else if (nonempty[1]) grant_oh = 3'b010;
        else if (nonempty[2]) grant_oh = 3'b100;
      end
    endcase
  end

  assign grant_valid = |grant_oh;
  assign grant_idx   = {grant_oh[2], grant_oh[1]};

  // Head-of-queue mux for the granted requester.
  always_comb begin
    sel_addr = head_addr[0];
    sel_data = head_data[0];
    if (grant_oh[1]) begin
      sel_addr = head_addr[1];
      sel_data = head_data[1];
    end else if (grant_oh[2]) begin
      sel_addr = head_addr[2];
      sel_data = head_data[2];
    end
  end

  // Issue register: r0 entries consume the grant but never raise w_en;
  // address/data hold whenever nothing is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_en           <= 1'b0;
      w_address_d_5  <= '0;
      w_data_dval_32 <= '0;
      last_grant     <= 2'd2;
    end else begin
      w_en <= grant_valid && (sel_addr != 5'd0);
      if (grant_valid) begin
        last_grant <= grant_idx;
        if (sel_addr != 5'd0) begin
          w_address_d_5  <= sel_addr;
          w_data_dval_32 <= sel_data;
        end
      end
    end
  end

  assign hazard_s1 = (w_address_s1_5 != 5'd0) &&
                     ((|match_s1) || (w_en && (w_address_d_5 == w_address_s1_5)));
  assign hazard_s2 = (w_address_s2_5 != 5'd0) &&
                     ((|match_s2) || (w_en && (w_address_d_5 == w_address_s2_5)));
  assign idle      = ~|nonempty && !w_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a directed vector table, an all-requesters
// saturation run with a mid-drain asynchronous reset, and a randomized run,
// all checked against a queue-based model of the write-back rules.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [4:0]  tb_addr [3];
  logic [31:0] tb_data [3];
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [4:0]  s1 = '0;
  logic [4:0]  s2 = '0;
  logic        hz1, hz2, idle;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid_3(req_valid), .req_ready_3(req_ready),
    .req_address_0_5(tb_addr[0]), .req_address_1_5(tb_addr[1]), .req_address_2_5(tb_addr[2]),
    .req_data_0_32(tb_data[0]), .req_data_1_32(tb_data[1]), .req_data_2_32(tb_data[2]),
    .w_en(w_en), .w_address_d_5(w_addr), .w_data_dval_32(w_data),
    .w_address_s1_5(s1), .w_address_s2_5(s2),
    .hazard_s1(hz1), .hazard_s2(hz2), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq [3][$];
  int          m_lg;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_lg = 2; m_wen = 1'b0; m_addr = '0; m_data = '0;
  endtask

  function automatic logic m_hz(input logic [4:0] s);
    if (s == 0) return 1'b0;
    if (m_wen && m_addr == s) return 1'b1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < mq[i].size(); k++)
        if (mq[i][k].a == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic m_idle();
    return (mq[0].size() + mq[1].size() + mq[2].size() == 0) && !m_wen;
  endfunction

  task automatic model_edge();
    logic [2:0] acc;
    bit got;
    int g;
    ent_t e;
    for (int i = 0; i < 3; i++) acc[i] = req_valid[i] && (mq[i].size() < DEPTH);
    got = 0;
    for (int k = 1; k <= 3; k++) begin
      g = (m_lg + k) % 3;
      if (!got && mq[g].size() > 0) begin
        got = 1;
        e = mq[g].pop_front();
        m_lg = g;
        if (e.a != 0) begin
          m_wen = 1'b1; m_addr = e.a; m_data = e.d;
        end else m_wen = 1'b0;
      end
    end
    if (!got) m_wen = 1'b0;
    for (int i = 0; i < 3; i++)
      if (acc[i]) mq[i].push_back('{a: tb_addr[i], d: tb_data[i]});
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, {29'd0, req_ready}, {29'd0, m_ready()});
    chk({tag, ".w_en"}, {31'd0, w_en}, {31'd0, m_wen});
    if (m_wen) begin
      chk({tag, ".w_addr"}, {27'd0, w_addr}, {27'd0, m_addr});
      chk({tag, ".w_data"}, w_data, m_data);
    end
    chk({tag, ".hz1"}, {31'd0, hz1}, {31'd0, m_hz(s1)});
    chk({tag, ".hz2"}, {31'd0, hz2}, {31'd0, m_hz(s2)});
    chk({tag, ".idle"}, {31'd0, idle}, {31'd0, m_idle()});
  endtask

  // One model-checked cycle: drive at negedge, check, then advance the model at posedge.
  task automatic model_cycle(input string tag, input logic [2:0] v,
                             input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clock);
    req_valid = v;
    tb_addr[0] = a0; tb_addr[1] = a1; tb_addr[2] = a2;
    for (int i = 0; i < 3; i++) tb_data[i] = $urandom;
    s1 = r1; s2 = r2;
    #1;
    check_model(tag);
    @(posedge clock);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clock);
    req_valid = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    s1 = '0; s2 = '0;
    #1;
    chk("rst.ready", {29'd0, req_ready}, 32'd7);
    chk("rst.w_en", {31'd0, w_en}, 32'd0);
    chk("rst.w_addr", {27'd0, w_addr}, 32'd0);
    chk("rst.w_data", w_data, 32'd0);
    chk("rst.hz", {30'd0, hz1, hz2}, 32'd0);
    chk("rst.idle", {31'd0, idle}, 32'd1);
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  r1, r2;
    logic [2:0]  e_rdy;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_h1, e_h2, e_idle;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // single r5 write, r0 discard on requester 1, back-to-back r3=1 then r3=2 on requester 2
    tbl[0]  = '{3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0,            5, 0, 3'b111, 0, 0, 0,            0, 0, 1};
    tbl[1]  = '{3'b000, 0, 0, 0, 0, 0, 0,                       5, 0, 3'b111, 0, 0, 0,            1, 0, 0};
    tbl[2]  = '{3'b000, 0, 0, 0, 0, 0, 0,                       5, 0, 3'b111, 1, 5, 32'hDEADBEEF, 1, 0, 0};
    tbl[3]  = '{3'b010, 0, 0, 0, 0, 32'h12345678, 0,            5, 0, 3'b111, 0, 5, 32'hDEADBEEF, 0, 0, 1};
    tbl[4]  = '{3'b000, 0, 0, 0, 0, 0, 0,                       0, 0, 3'b111, 0, 5, 32'hDEADBEEF, 0, 0, 0};
    tbl[5]  = '{3'b000, 0, 0, 0, 0, 0, 0,                       0, 0, 3'b111, 0, 5, 32'hDEADBEEF, 0, 0, 1};
    tbl[6]  = '{3'b100, 0, 0, 3, 0, 0, 1,                       0, 0, 3'b111, 0, 5, 32'hDEADBEEF, 0, 0, 1};
    tbl[7]  = '{3'b100, 0, 0, 3, 0, 0, 2,                       3, 0, 3'b111, 0, 5, 32'hDEADBEEF, 1, 0, 0};
    tbl[8]  = '{3'b000, 0, 0, 0, 0, 0, 0,                       3, 0, 3'b111, 1, 3, 1,            1, 0, 0};
    tbl[9]  = '{3'b000, 0, 0, 0, 0, 0, 0,                       3, 0, 3'b111, 1, 3, 2,            1, 0, 0};
    tbl[10] = '{3'b000, 0, 0, 0, 0, 0, 0,                       3, 0, 3'b111, 0, 3, 2,            0, 0, 1};

    for (int i = 0; i < 3; i++) begin tb_addr[i] = '0; tb_data[i] = '0; end

    // power-up reset
    reset = 1'b1;
    #12;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      req_valid = tbl[i].v;
      tb_addr[0] = tbl[i].a0; tb_addr[1] = tbl[i].a1; tb_addr[2] = tbl[i].a2;
      tb_data[0] = tbl[i].d0; tb_data[1] = tbl[i].d1; tb_data[2] = tbl[i].d2;
      s1 = tbl[i].r1; s2 = tbl[i].r2;
      #1;
      chk($sformatf("tbl%0d.ready", i), {29'd0, req_ready}, {29'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d.w_en", i), {31'd0, w_en}, {31'd0, tbl[i].e_wen});
      chk($sformatf("tbl%0d.w_addr", i), {27'd0, w_addr}, {27'd0, tbl[i].e_addr});
      chk($sformatf("tbl%0d.w_data", i), w_data, tbl[i].e_data);
      chk($sformatf("tbl%0d.hz1", i), {31'd0, hz1}, {31'd0, tbl[i].e_h1});
      chk($sformatf("tbl%0d.hz2", i), {31'd0, hz2}, {31'd0, tbl[i].e_h2});
      chk($sformatf("tbl%0d.idle", i), {31'd0, idle}, {31'd0, tbl[i].e_idle});
    end

    // saturation: all requesters every cycle with distinct addresses
    do_reset();
    for (int c = 0; c < 10; c++)
      model_cycle("sat", 3'b111, 5'(c % 7 + 1), 5'(c % 7 + 10), 5'(c % 7 + 20), 5'(c % 7 + 20), 5'd9);

    // reset asserted mid-drain between clock edges
    @(negedge clock);
    req_valid = '0;
    s1 = 5'd20; s2 = 5'd10;
    #2 reset = 1'b1;
    #1;
    chk("midrst.w_en", {31'd0, w_en}, 32'd0);
    chk("midrst.ready", {29'd0, req_ready}, 32'd7);
    chk("midrst.idle", {31'd0, idle}, 32'd1);
    chk("midrst.hz", {30'd0, hz1, hz2}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++)
      model_cycle("postrst", 3'b000, 5'd0, 5'd0, 5'd0, 5'd20, 5'd10);

    // randomized traffic over a small address range to exercise hazards and r0
    for (int c = 0; c < 400; c++)
      model_cycle("rand", 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    // drain and confirm quiescence
    for (int c = 0; c < 3 * DEPTH + 2; c++)
      model_cycle("drain", 3'b000, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2);
    chk("final.idle", {31'd0, idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
